// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   OP_*      operation encodings driven on the op port
//   state_t   FSM states of mult_div_unit (IDLE -> CALC -> FIX -> IDLE)
//   is_signed true for MULT and DIV (operands are two's complement)
//   is_divide true for DIV and DIVU
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_divide(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration of the multiply/divide datapath (combinational).
// Ports:
//   acc       in   2*WIDTH  current accumulator {upper half, lower half}
//   operand   in   WIDTH    magnitude of the multiplier / divisor
//   is_div    in   1        1 = restoring divide step, 0 = shift-add multiply step
//   acc_next  out  2*WIDTH  accumulator after this iteration
// Multiply: lower half starts as the multiplicand and is consumed LSB first;
//   the partial product grows into the upper half from the top.
// Divide: lower half starts as the dividend and is replaced by quotient bits
//   from the bottom; the upper half holds the running remainder.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  // The trial subtraction uses the remainder shifted left by one with the next
  // dividend bit appended; a borrow in the top bit means "restore" (keep shift).
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    acc_next = acc;
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      begin operation (sampled only when idle)
//   op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in   WIDTH  multiplicand / dividend
//   b      in   WIDTH  multiplier / divisor
//   hi_we  in   1      MTHI write enable (only when not busy)
//   lo_we  in   1      MTLO write enable (only when not busy)
//   wd     in   WIDTH  MTHI/MTLO write data
//   busy   out  1      operation in flight
//   done   out  1      one-cycle pulse when hi/lo hold a new result
//   hi     out  WIDTH  HI register (remainder / product upper half)
//   lo     out  WIDTH  LO register (quotient / product lower half)
// The core works on magnitudes; signs are latched at start and applied in FIX.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, next_state;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0]   operand_b, a_raw, a_abs, b_abs;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo, hi_q, lo_q;
  logic [1:0]         op_q;
  logic               sign_a, sign_b, b_zero, done_q;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand_b),
    .is_div   (is_divide(op_q)),
    .acc_next (acc_next)
  );

  // Magnitudes of the incoming operands; unsigned ops pass through untouched.
  always_comb begin
    a_abs = (is_signed(op) && a[WIDTH-1]) ? -a : a;
    b_abs = (is_signed(op) && b[WIDTH-1]) ? -b : b;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: CALC runs until the counter hits zero, FIX always takes one cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CALC;
      S_CALC:  if (counter == CW'(1)) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture at start and one datapath iteration per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      acc       <= '0;
      operand_b <= '0;
      a_raw     <= '0;
      op_q      <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
    end else if (state == S_IDLE && start) begin
      counter   <= CW'(WIDTH);
      acc       <= {{WIDTH{1'b0}}, a_abs};
      operand_b <= b_abs;
      a_raw     <= a;
      op_q      <= op;
      sign_a    <= is_signed(op) & a[WIDTH-1];
      sign_b    <= is_signed(op) & b[WIDTH-1];
      b_zero    <= (b == '0);
    end else if (state == S_CALC) begin
      acc     <= acc_next;
      counter <= counter - CW'(1);
    end
  end

  // Sign correction. Remainder follows the dividend's sign; divide by zero
  // returns the raw dividend in HI and all-ones in LO with no sign fix.
  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    quo    = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_divide(op_q)) begin
      if (b_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
  end

  // HI/LO: results land on the FIX edge; MTHI/MTLO are honoured only while idle,
  // so a write in the start cycle lands and is later overwritten by the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_FIX);
      if (state == S_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (state == S_IDLE) begin
        if (hi_we) hi_q <= wd;
        if (lo_we) lo_q <= wd;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit (WIDTH = 32).
// Expected HI/LO come from plain 64-bit arithmetic on the operands.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wd = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: MIPS-style results from ordinary 64-bit arithmetic.
  task automatic refModel(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          output logic [31:0] exp_hi, output logic [31:0] exp_lo);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up, uq, ur;
    sa = longint'($signed(a_i));
    sb = longint'($signed(b_i));
    exp_hi = '0;
    exp_lo = '0;
    case (op_i)
      2'b00: begin
        sp = sa * sb;
        exp_hi = sp[63:32];
        exp_lo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a_i} * {32'd0, b_i};
        exp_hi = up[63:32];
        exp_lo = up[31:0];
      end
      2'b10: begin
        if (b_i == 0) begin
          exp_hi = a_i;
          exp_lo = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          exp_hi = sr[31:0];
          exp_lo = sq[31:0];
        end
      end
      default: begin
        if (b_i == 0) begin
          exp_hi = a_i;
          exp_lo = 32'hFFFF_FFFF;
        end else begin
          uq = {32'd0, a_i} / {32'd0, b_i};
          ur = {32'd0, a_i} % {32'd0, b_i};
          exp_hi = ur[31:0];
          exp_lo = uq[31:0];
        end
      end
    endcase
  endtask

  // Runs one operation from start to done and checks timing and result.
  // mode 0: plain; mode 1: MTLO and a second start injected while busy;
  // mode 2: MTHI issued in the same cycle as start.
  task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a_i,
                               input logic [31:0] b_i, input int mode);
    logic [31:0] exp_hi, exp_lo, lo_before;
    int          cycles, busy_cycles;
    bit          seen;
    refModel(op_i, a_i, b_i, exp_hi, exp_lo);
    @(negedge clk);
    start = 1'b1;
    op = op_i;
    a = a_i;
    b = b_i;
    if (mode == 2) begin
      hi_we = 1'b1;
      wd = 32'h0BAD_F00D;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    lo_before = lo;
    checkOutput("busy_at_start", 32'(busy), 32'd1);
    checkOutput("done_at_start", 32'(done), 32'd0);
    if (mode == 2) checkOutput("mthi_with_start", hi, 32'h0BAD_F00D);
    busy_cycles = 1;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
      if (mode == 1 && cycles == 6) begin
        lo_we = 1'b0;
        start = 1'b0;
        checkOutput("mtlo_while_busy", lo, lo_before);
      end
      if (mode == 1 && cycles == 5) begin
        @(negedge clk);
        lo_we = 1'b1;
        wd = 32'hDEAD_BEEF;
        start = 1'b1;
        op = op_i ^ 2'b10;
        a = 32'h1357_9BDF;
        b = 32'h0000_0003;
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    checkOutput("latency", 32'(cycles), 32'd33);
    checkOutput("busy_cycles", 32'(busy_cycles), 32'd33);
    checkOutput("busy_in_done", 32'(busy), 32'd0);
    checkOutput("hi", hi, exp_hi);
    checkOutput("lo", lo, exp_lo);
  endtask

  initial begin
    int done_count;
    int sel;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, including back-to-back starts in the done cycle.
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(2'b11, 32'd100, 32'd7, 0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(2'b11, 32'd5, 32'd0, 0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd0, 0);

    // MTHI while idle.
    @(negedge clk);
    hi_we = 1'b1;
    wd = 32'h0000_1234;
    r_a = lo;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    checkOutput("mthi_idle", hi, 32'h0000_1234);
    checkOutput("mthi_lo_kept", lo, r_a);

    // MTLO and start while busy, then MTHI together with start.
    applyStimulus(2'b00, 32'h0001_0003, 32'hFFFF_0007, 1);
    applyStimulus(2'b11, 32'hCAFE_0000, 32'h0000_0101, 2);

    // Reset in the middle of a MULT.
    @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    a = 32'h1234_5678;
    b = 32'h8765_4321;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_count++;
    end
    checkOutput("no_done_after_rst", 32'(done_count), 32'd0);
    applyStimulus(2'b11, 32'd9, 32'd3, 0);

    // Randomized operations with a bias toward corner operands.
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom);
      r_a = $urandom;
      r_b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) r_b = 32'd0;
      else if (sel == 1) r_b = 32'($urandom_range(1, 15));
      else if (sel == 2) r_a = 32'h8000_0000;
      else if (sel == 3) r_b = 32'hFFFF_FFFF;
      applyStimulus(r_op, r_a, r_b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
